// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// adder_subtractor: 1-bit full adder / full subtractor cell.
//   M  : 0 = add, 1 = subtract (A - B - Te)
//   A,B: operand bits
//   Te : carry-in (add) / borrow-in (sub)
//   S  : sum / difference bit
//   Ts : carry-out (add) / borrow-out (sub)
// -----------------------------------------------------------------------------
module adder_subtractor (
    input  logic M,
    input  logic A,
    input  logic B,
    input  logic Te,
    output logic S,
    output logic Ts
);
    logic aEff;

    // Inverting A turns the carry equation into the borrow equation.
    assign aEff = A ^ M;
    assign S    = A ^ B ^ Te;
    assign Ts   = (aEff & B) | (Te & (aEff ^ B));
endmodule

// -----------------------------------------------------------------------------
// serial_addsub_ctrl: bit-serial WIDTH-bit adder/subtractor sharing one
// adder_subtractor cell, LSB first, with a start/busy/done handshake.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request an operation (accepted only while ready)
//   mode          : 0 = op_a + op_b, 1 = op_a - op_b (latched on accept)
//   op_a, op_b    : operands (latched on accept)
//   ready         : idle, start will be accepted this cycle
//   busy          : serial operation in progress
//   done          : one-cycle pulse, result/carry_out/overflow are final
//   result        : sum/difference, held until the next completion
//   carry_out     : carry (add) or borrow (sub)
//   overflow      : signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic               readyNext;
    logic               busyNext;
    logic               doneNext;

    logic [WIDTH-1:0]   aSh;
    logic [WIDTH-1:0]   bSh;
    logic [WIDTH-1:0]   sSh;
    logic [CNT_W-1:0]   cnt;
    logic               teFlop;
    logic               modeLat;
    logic               aMsb;
    logic               bMsb;

    logic               cellS;
    logic               cellTs;
    logic               lastBit;
    logic               accept;

    assign accept  = (state == IDLE) && start;
    assign lastBit = (cnt == CNT_W'(WIDTH - 1));

    // The single shared arithmetic cell
    adder_subtractor uCell (
        .M  (modeLat),
        .A  (aSh[0]),
        .B  (bSh[0]),
        .Te (teFlop),
        .S  (cellS),
        .Ts (cellTs)
    );

    // State and handshake flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= stateNext;
            ready <= readyNext;
            busy  <= busyNext;
            done  <= doneNext;
        end
    end

    // Next-state and next-flag logic; flags are registered copies of the next state
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastBit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        readyNext = (stateNext == IDLE);
        busyNext  = (stateNext == RUN);
        doneNext  = (stateNext == DONE);
    end

    // Serial datapath: operand/sum shift registers, carry flop, bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            aSh       <= '0;
            bSh       <= '0;
            sSh       <= '0;
            cnt       <= '0;
            teFlop    <= 1'b0;
            modeLat   <= 1'b0;
            aMsb      <= 1'b0;
            bMsb      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            aSh     <= op_a;
            bSh     <= op_b;
            modeLat <= mode;
            aMsb    <= op_a[WIDTH-1];
            bMsb    <= op_b[WIDTH-1];
            teFlop  <= 1'b0;
            cnt     <= '0;
        end else if (state == RUN) begin
            sSh    <= {cellS, sSh[WIDTH-1:1]};
            aSh    <= aSh >> 1;
            bSh    <= bSh >> 1;
            teFlop <= cellTs;
            cnt    <= cnt + CNT_W'(1);
            if (lastBit) begin
                result    <= {cellS, sSh[WIDTH-1:1]};
                carry_out <= cellTs;
                // Subtraction overflows when operand signs differ, addition when they match
                overflow  <= ((aMsb ^ bMsb) == modeLat) && (cellS != aMsb);
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for serial_addsub_ctrl (WIDTH = 8).
// An arithmetic reference model tracks the operation phase and expected
// results; a negedge compare process checks every output each cycle.
// -----------------------------------------------------------------------------
module tb_serial_addsub_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .op_a      (op_a),
        .op_b      (op_b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase -1 = idle, 0..W-1 = running, W = done cycle
    int           phase = -1;
    int           cyc = 0;
    logic [W-1:0] mRes = '0, pRes = '0;
    logic         mCarry = 1'b0, mOvf = 1'b0, pCarry = 1'b0, pOvf = 1'b0;

    always @(posedge clk) begin
        int sa, sb, sr, ua, ub, ur;
        cyc++;
        if (rst) begin
            phase = -1;
            mRes = '0; mCarry = 1'b0; mOvf = 1'b0;
        end else if (phase == -1) begin
            if (start) begin
                phase = 0;
                ua = int'(op_a); ub = int'(op_b);
                sa = int'($signed(op_a)); sb = int'($signed(op_b));
                if (mode) begin
                    ur = ua - ub; sr = sa - sb;
                    pCarry = (ua < ub);
                end else begin
                    ur = ua + ub; sr = sa + sb;
                    pCarry = (ur > 255);
                end
                pRes = W'(ur & 255);
                pOvf = (sr > 127) || (sr < -128);
            end
        end else if (phase < W - 1) begin
            phase++;
        end else if (phase == W - 1) begin
            phase = W;
            mRes = pRes; mCarry = pCarry; mOvf = pOvf;
        end else begin
            phase = -1;
        end
    end

    // Every-cycle comparison against the model, plus done-spacing tracking
    bit checkEn = 1'b0;
    bit spacingEn = 1'b0;
    int lastDone = -1;

    always @(negedge clk) begin
        if (checkEn) begin
            check("ready", ready, phase == -1);
            check("busy", busy, (phase >= 0) && (phase < W));
            check("done", done, phase == W);
            check("result", result, mRes);
            check("carry_out", carry_out, mCarry);
            check("overflow", overflow, mOvf);
            if (done && spacingEn) begin
                if (lastDone >= 0) check("done_spacing", cyc - lastDone, 10);
                lastDone = cyc;
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    // Issue one operation and wait for done; returns outputs seen on done
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         output logic [W-1:0] r, output logic c, output logic o,
                         output int busyCnt);
        int n = 0;
        waitReady();
        op_a = a; op_b = b; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busyCnt = 0;
        while (!done && n < 40) begin
            if (busy) busyCnt++;
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", done, 1);
        r = result; c = carry_out; o = overflow;
    endtask

    initial begin
        logic [W-1:0] r;
        logic         c, o;
        int           bc;
        int           doneCnt;

        rst = 1'b1; start = 1'b0; mode = 1'b0; op_a = '0; op_b = '0;
        @(negedge clk);
        @(negedge clk);
        checkEn = 1'b1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed literal cases
        runOp(8'h35, 8'h4A, 1'b0, r, c, o, bc);
        check("t1_busy_cycles", bc, 8);
        check("t1_result", r, 8'h7F); check("t1_carry", c, 0); check("t1_ovf", o, 0);
        runOp(8'hFF, 8'h01, 1'b0, r, c, o, bc);
        check("t2a_result", r, 8'h00); check("t2a_carry", c, 1); check("t2a_ovf", o, 0);
        runOp(8'h7F, 8'h01, 1'b0, r, c, o, bc);
        check("t2b_result", r, 8'h80); check("t2b_carry", c, 0); check("t2b_ovf", o, 1);
        runOp(8'h05, 8'h07, 1'b1, r, c, o, bc);
        check("t3a_result", r, 8'hFE); check("t3a_borrow", c, 1); check("t3a_ovf", o, 0);
        runOp(8'h80, 8'h01, 1'b1, r, c, o, bc);
        check("t3b_result", r, 8'h7F); check("t3b_borrow", c, 0); check("t3b_ovf", o, 1);

        // start held high while operands and mode churn every cycle
        waitReady();
        lastDone = -1; spacingEn = 1'b1; doneCnt = 0;
        op_a = 8'h12; op_b = 8'h34; mode = 1'b0; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
            op_a = W'($urandom); op_b = W'($urandom); mode = 1'($urandom);
        end
        start = 1'b0; spacingEn = 1'b0;
        check("t4_done_count", doneCnt, 3);

        // Reset during the 4th RUN cycle aborts the operation
        waitReady();
        @(negedge clk);
        op_a = 8'h11; op_b = 8'h22; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_pre_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ready", ready, 1); check("t5_busy", busy, 0);
        check("t5_done", done, 0); check("t5_result", result, 0);
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        check("t5_no_done", doneCnt, 0);
        runOp(8'h10, 8'h20, 1'b0, r, c, o, bc);
        check("t5_result_after", r, 8'h30);

        // Randomized operations with random idle gaps
        for (int i = 0; i < 1500; i++) begin
            runOp(W'($urandom), W'($urandom), 1'($urandom), r, c, o, bc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Operand extremes in both modes
        for (int i = 0; i < 16; i++) begin
            logic [3:0] sel;
            logic [W-1:0] av, bv;
            sel = 4'(i);
            av = sel[0] ? 8'hFF : (sel[1] ? 8'h80 : 8'h00);
            bv = sel[2] ? 8'h7F : 8'h80;
            runOp(av, bv, sel[3], r, c, o, bc);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
